// File: rtl/sdram_loader_pkg.sv
// Shared types and constants for the SDRAM ROM loader: issue FSM states,
// byte-enable codes, the write-queue entry layout and address arithmetic.
package sdram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } issue_state_t;

  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_W  = 2'b11;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  ds;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

  // Byte address to SDRAM word address, offset by base and wrapped to 23 bits.
  function automatic logic [22:0] word_addr(input logic [24:0] byte_addr,
                                            input logic [22:0] base);
    logic [23:0] sum;
    sum = byte_addr[24:1] + {1'b0, base};
    return sum[22:0];
  endfunction

endpackage

// File: rtl/sdram_rom_loader_fifo.sv
// Small synchronous FIFO holding packed SDRAM write entries. Head is
// presented combinationally; pointers wrap because DEPTH is a power of two.
module loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only taken when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs a downloaded ROM byte stream into 16-bit SDRAM writes, queues them,
// and issues them one at a time over a toggle req/ack port.
//
// state    | meaning
// IDLE     | no request outstanding, waiting for a queued entry
// ISSUE    | latch queue head onto the port and toggle port_req
// WAIT_ACK | request outstanding until port_ack matches port_req
module sdram_rom_loader
  import sdram_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [22:0] BASE       = 23'd0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port_req,
  input  logic        port_ack,
  output logic        port_we,
  output logic [23:1] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        rom_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 2);

  logic         downl_q;
  logic         downl_rise;
  logic         downl_fall;
  logic         wr_byte;
  logic [22:0]  in_addr;

  logic         held_valid, held_valid_nxt;
  logic [22:0]  held_addr, held_addr_nxt;
  logic [7:0]   held_lo, held_lo_nxt;
  logic         pend_valid, pend_valid_nxt;
  wr_entry_t    pend_entry, pend_entry_nxt;
  wr_entry_t    held_entry;
  wr_entry_t    odd_entry;

  logic         push;
  wr_entry_t    push_entry;
  logic         pop;
  wr_entry_t    fifo_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;

  issue_state_t state, state_nxt;
  logic         load_port;
  logic         dl_seen;

  assign downl_rise = ioctl_downl && !downl_q;
  assign downl_fall = !ioctl_downl && downl_q;
  assign wr_byte    = ioctl_wr && ioctl_downl;
  assign in_addr    = word_addr(ioctl_addr, BASE);
  assign held_entry = '{addr: held_addr, data: {8'h00, held_lo}, ds: DS_LO};
  assign odd_entry  = '{addr: in_addr, data: {ioctl_dout, 8'h00}, ds: DS_HI};

  // A deferred odd byte keeps the source stalled until it has been queued.
  assign ioctl_wait = fifo_full || (fifo_count >= WAIT_LVL) || pend_valid;

  // Byte packing: decide this cycle's single queue push and the next pack state.
  // A deferred entry always exists with the pack register empty, so it never
  // competes with a held-word push.
  always_comb begin
    push           = 1'b0;
    push_entry     = '0;
    held_valid_nxt = held_valid;
    held_addr_nxt  = held_addr;
    held_lo_nxt    = held_lo;
    pend_valid_nxt = 1'b0;
    pend_entry_nxt = pend_entry;

    if (pend_valid) begin
      push       = 1'b1;
      push_entry = pend_entry;
    end

    if (wr_byte) begin
      if (!ioctl_addr[0]) begin
        if (held_valid) begin
          push       = 1'b1;
          push_entry = held_entry;
        end
        held_valid_nxt = 1'b1;
        held_addr_nxt  = in_addr;
        held_lo_nxt    = ioctl_dout;
      end else if (held_valid && (held_addr == in_addr)) begin
        push           = 1'b1;
        push_entry     = '{addr: held_addr, data: {ioctl_dout, held_lo}, ds: DS_W};
        held_valid_nxt = 1'b0;
      end else if (held_valid) begin
        push           = 1'b1;
        push_entry     = held_entry;
        held_valid_nxt = 1'b0;
        pend_valid_nxt = 1'b1;
        pend_entry_nxt = odd_entry;
      end else if (pend_valid) begin
        pend_valid_nxt = 1'b1;
        pend_entry_nxt = odd_entry;
      end else begin
        push       = 1'b1;
        push_entry = odd_entry;
      end
    end else if (downl_fall && held_valid) begin
      push           = 1'b1;
      push_entry     = held_entry;
      held_valid_nxt = 1'b0;
    end
  end

  // Pack register, deferred odd entry and download edge tracking.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      downl_q    <= 1'b0;
      held_valid <= 1'b0;
      held_addr  <= '0;
      held_lo    <= '0;
      pend_valid <= 1'b0;
      pend_entry <= '0;
    end else begin
      downl_q    <= ioctl_downl;
      held_valid <= held_valid_nxt;
      held_addr  <= held_addr_nxt;
      held_lo    <= held_lo_nxt;
      pend_valid <= pend_valid_nxt;
      pend_entry <= pend_entry_nxt;
    end
  end

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .init_n    (init_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue FSM next state; the head is popped on the acknowledge cycle.
  always_comb begin
    state_nxt = state;
    load_port = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        load_port = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (port_ack == port_req) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port registers: held stable from the request toggle until the acknowledge.
  // Reset aligns port_req with port_ack so an abandoned transfer is not re-sent.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      port_req <= port_ack;
      port_we  <= 1'b0;
      port_a   <= '0;
      port_d   <= '0;
      port_ds  <= '0;
    end else if (load_port) begin
      port_req <= ~port_req;
      port_we  <= 1'b1;
      port_a   <= fifo_head.addr;
      port_d   <= fifo_head.data;
      port_ds  <= fifo_head.ds;
    end else if (pop) begin
      port_we  <= 1'b0;
    end
  end

  // rom_ready: only meaningful after a download has been seen since reset.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      rom_ready <= 1'b0;
      dl_seen   <= 1'b0;
    end else if (downl_rise) begin
      rom_ready <= 1'b0;
      dl_seen   <= 1'b1;
    end else if (dl_seen && !ioctl_downl && !held_valid && !pend_valid &&
                 fifo_empty && (state == IDLE)) begin
      rom_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Directed bench for sdram_rom_loader: an SDRAM port model echoes acks and
// logs every issued write; a second instance checks the BASE offset.
module tb_sdram_rom_loader;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        port_req;
  logic        port_ack = 1'b0;
  logic        port_we;
  logic [23:1] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        rom_ready;

  logic        wait_b, req_b, we_b, ready_b;
  logic        ack_b = 1'b0;
  logic [23:1] a_b;
  logic [1:0]  ds_b;
  logic [15:0] d_b;

  int n_checks = 0;
  int n_pass = 0;
  int n_writes = 0;
  int stab_err = 0;
  int ack_delay = 3;
  int ack_hold = 0;
  int ack_timer = 0;
  bit pending = 1'b0;
  logic req_seen = 1'b0;
  logic [22:0] log_a [64];
  logic [15:0] log_d [64];
  logic [1:0]  log_ds [64];
  logic        log_we [64];

  always #5 clk = ~clk;

  sdram_rom_loader #(.FIFO_DEPTH(4), .BASE(23'd0)) dut (
    .clk(clk), .init_n(init_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .rom_ready(rom_ready)
  );

  sdram_rom_loader #(.FIFO_DEPTH(4), .BASE(23'h100000)) dut_b (
    .clk(clk), .init_n(init_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(wait_b),
    .port_req(req_b), .port_ack(ack_b), .port_we(we_b), .port_a(a_b),
    .port_ds(ds_b), .port_d(d_b), .rom_ready(ready_b)
  );

  // Instance B's port acknowledges one cycle after each request.
  always @(posedge clk) begin
    #1;
    ack_b = req_b;
  end

  // SDRAM port model for the main instance: log, check stability, echo ack.
  always @(posedge clk) begin
    #1;
    if (ack_hold > 0) ack_hold--;
    if (!init_n) begin
      pending = 1'b0;
      req_seen = port_req;
    end else if (port_req !== req_seen) begin
      req_seen = port_req;
      if (n_writes < 64) begin
        log_a[n_writes]  = port_a;
        log_d[n_writes]  = port_d;
        log_ds[n_writes] = port_ds;
        log_we[n_writes] = port_we;
      end
      n_writes++;
      pending = 1'b1;
      ack_timer = ack_delay;
    end else if (pending) begin
      if (n_writes <= 64 &&
          (port_a !== log_a[n_writes-1] || port_d !== log_d[n_writes-1] ||
           port_ds !== log_ds[n_writes-1] || port_we !== log_we[n_writes-1]))
        stab_err++;
      if (ack_timer > 1) ack_timer--;
      else if (ack_hold == 0) begin
        port_ack = port_req;
        pending = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("wait_timeout", ioctl_wait, 0);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int guard = 0;
    while (n_writes < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, n_writes, target);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!rom_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, rom_ready, 1);
  endtask

  initial begin
    logic [7:0] lo, hi;

    // reset state
    init_n = 1'b0;
    cycles(3);
    check("rst_ready", rom_ready, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_we", port_we, 0);
    check("rst_ds", port_ds, 0);
    check("rst_a", port_a, 0);
    check("rst_d", port_d, 0);
    check("rst_req", port_req, 0);
    init_n = 1'b1;
    cycles(3);
    check("idle_ready", rom_ready, 0);

    // byte pair merges into one full-word write
    ioctl_downl = 1'b1;
    cycles(2);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    wait_writes(1, "t1_count");
    cycles(2);
    check("t1_ready_during", rom_ready, 0);
    ioctl_downl = 1'b0;
    wait_ready("t1_ready");
    check("t1_a", log_a[0], 23'd0);
    check("t1_d", log_d[0], 16'h2211);
    check("t1_ds", log_ds[0], 2'b11);
    check("t1_we", log_we[0], 1);

    // lone odd byte
    ioctl_downl = 1'b1;
    cycles(1);
    check("t2_ready_clr", rom_ready, 0);
    send_byte(25'd5, 8'hAB);
    ioctl_downl = 1'b0;
    wait_writes(2, "t2_count");
    wait_ready("t2_ready");
    check("t2_a", log_a[1], 23'd2);
    check("t2_dhi", log_d[1][15:8], 8'hAB);
    check("t2_ds", log_ds[1], 2'b10);

    // two even bytes: first pushed by the second, second by the flush
    ioctl_downl = 1'b1;
    cycles(1);
    send_byte(25'd8, 8'hCD);
    send_byte(25'd12, 8'hEF);
    wait_writes(3, "t3_count1");
    cycles(10);
    check("t3_held", n_writes, 3);
    check("t3_a0", log_a[2], 23'd4);
    check("t3_ds0", log_ds[2], 2'b01);
    check("t3_dlo0", log_d[2][7:0], 8'hCD);
    ioctl_downl = 1'b0;
    wait_writes(4, "t3_count2");
    wait_ready("t3_ready");
    check("t3_a1", log_a[3], 23'd6);
    check("t3_ds1", log_ds[3], 2'b01);
    check("t3_dlo1", log_d[3][7:0], 8'hEF);

    // odd byte not matching the held word: two pushes in order
    ioctl_downl = 1'b1;
    cycles(1);
    send_byte(25'h20, 8'h01);
    send_byte(25'h23, 8'h02);
    check("t4_wait_pair", ioctl_wait, 1);
    ioctl_downl = 1'b0;
    wait_writes(6, "t4_count");
    wait_ready("t4_ready");
    check("t4_a0", log_a[4], 23'h10);
    check("t4_ds0", log_ds[4], 2'b01);
    check("t4_dlo0", log_d[4][7:0], 8'h01);
    check("t4_a1", log_a[5], 23'h11);
    check("t4_ds1", log_ds[5], 2'b10);
    check("t4_dhi1", log_d[5][15:8], 8'h02);

    // strobe outside a download is ignored
    send_byte(25'h30, 8'h99);
    cycles(20);
    check("t5_ignored", n_writes, 6);
    check("t5_ready", rom_ready, 1);

    // BASE offset on instance B
    ioctl_downl = 1'b1;
    cycles(1);
    send_byte(25'h10, 8'h5A);
    send_byte(25'h11, 8'hA5);
    wait_writes(7, "t6_count");
    cycles(10);
    check("t6_b_a", a_b, 23'h100008);
    check("t6_b_ds", ds_b, 2'b11);
    check("t6_b_d", d_b, 16'hA55A);
    check("t6_a", log_a[6], 23'h8);
    check("t6_d", log_d[6], 16'hA55A);
    ioctl_downl = 1'b0;
    wait_ready("t6_ready");

    // burst with acknowledge held off
    ioctl_downl = 1'b1;
    cycles(1);
    ack_hold = 50;
    send_byte(25'h40, 8'h30);
    send_byte(25'h41, 8'h31);
    check("t7_wait_cnt1", ioctl_wait, 0);
    send_byte(25'h42, 8'h32);
    send_byte(25'h43, 8'h33);
    check("t7_wait_cnt2", ioctl_wait, 1);
    for (int i = 4; i < 16; i++) send_byte(25'(8'h40 + i), 8'(8'h30 + i));
    ioctl_downl = 1'b0;
    wait_writes(15, "t7_count");
    wait_ready("t7_ready");
    for (int k = 0; k < 8; k++) begin
      lo = 8'(8'h30 + 2 * k);
      hi = 8'(8'h31 + 2 * k);
      check($sformatf("t7_a%0d", k), log_a[7+k], 23'(8'h20 + k));
      check($sformatf("t7_d%0d", k), log_d[7+k], {hi, lo});
      check($sformatf("t7_ds%0d", k), log_ds[7+k], 2'b11);
    end

    // reset during WAIT_ACK abandons the transfer
    ioctl_downl = 1'b1;
    cycles(1);
    ack_hold = 100;
    send_byte(25'h60, 8'h77);
    send_byte(25'h61, 8'h88);
    wait_writes(16, "t8_count");
    cycles(2);
    check("t8_req_out", port_req, 0);
    port_ack = 1'b1;
    init_n = 1'b0;
    cycles(2);
    init_n = 1'b1;
    ack_hold = 0;
    cycles(1);
    check("t8_req", port_req, 1);
    check("t8_we", port_we, 0);
    check("t8_ds", port_ds, 0);
    check("t8_a", port_a, 0);
    check("t8_wait", ioctl_wait, 0);
    check("t8_ready", rom_ready, 0);
    cycles(20);
    check("t8_no_reissue", n_writes, 16);
    check("t8_req_stable", port_req, 1);
    ioctl_downl = 1'b0;
    wait_ready("t8_ready_empty");
    check("t8_no_write", n_writes, 16);

    check("port_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_rom_loader.md
SDRAM_ROM_LOADER -- requirements
Module: sdram_rom_loader

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of packed-word entries in the write FIFO (a power of two, at least 4).
REQ-002 The module SHALL have parameter BASE, width 23 bits, default 0, a word offset added to every SDRAM address.
REQ-003 Port clk, input, 1 bit: the single clock, shared with the SDRAM controller.
REQ-004 Port init_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port ioctl_downl, input, 1 bit: high while a ROM download is active.
REQ-006 Port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-007 Port ioctl_addr, input, 25 bits: byte address of the strobed byte.
REQ-008 Port ioctl_dout, input, 8 bits: the strobed byte.
REQ-009 Port ioctl_wait, output, 1 bit: backpressure to the byte source.
REQ-010 Port port_req, output, 1 bit: toggle-style request to the SDRAM port.
REQ-011 Port port_ack, input, 1 bit: toggle-style acknowledge from the SDRAM port.
REQ-012 Port port_we, output, 1 bit: write enable.
REQ-013 Port port_a, output, 23 bits ([23:1]): SDRAM word address.
REQ-014 Port port_ds, output, 2 bits: byte enables, bit1 = upper byte, bit0 = lower byte.
REQ-015 Port port_d, output, 16 bits: write data.
REQ-016 Port rom_ready, output, 1 bit: high once the last download has fully reached SDRAM.

Function
REQ-017 Byte packing SHALL work as follows.
- Even ioctl_addr: byte goes to word bits [7:0].
- Odd ioctl_addr: byte goes to word bits [15:8].
- Word address = ioctl_addr[24:1] + BASE, truncated to 23 bits.
REQ-018 An even byte SHALL be held in a one-word pack register (ds=01), not pushed.
REQ-019 An odd byte whose word address equals the held word SHALL merge into it and push one entry with ds=11.
REQ-020 An even byte arriving while a word is held SHALL push the held word with ds=01, then hold the new byte.
REQ-021 An odd byte with no matching held word SHALL push the held word if present, then push itself with ds=10, in that order over consecutive cycles.
REQ-022 The falling edge of ioctl_downl SHALL flush the held word (ds=01) into the FIFO.
REQ-023 The FIFO SHALL store {address, data, ds}, with FIFO_DEPTH entries and wrapping read/write pointers.
- The count SHALL have log2(FIFO_DEPTH)+1 bits.
- A simultaneous push and pop SHALL leave the count unchanged.
REQ-024 ioctl_wait SHALL be high whenever count >= FIFO_DEPTH-2, or while a two-entry push sequence (REQ-021) is in progress.
REQ-025 Bytes strobed while ioctl_wait is high SHALL still be accepted; the FIFO SHALL never overflow.
REQ-026 The issue FSM SHALL have three states: IDLE, ISSUE, WAIT_ACK.
- IDLE -> ISSUE when the FIFO is non-empty.
- ISSUE: drive port_a, port_d and port_ds from the FIFO head, set port_we=1, toggle port_req; go to WAIT_ACK.
- WAIT_ACK -> IDLE when port_ack == port_req; pop the head on that same cycle.
REQ-027 There SHALL be at most one outstanding request, and port_a, port_d, port_ds and port_we SHALL be stable from the toggle until the acknowledge.
REQ-028 rom_ready SHALL be cleared on the rising edge of ioctl_downl.
REQ-029 rom_ready SHALL be set on the first cycle where all of the following hold: ioctl_downl is low, the flush is done, the FIFO is empty, and the FSM is in IDLE.
REQ-030 A new download starting while the FIFO is still draining SHALL continue without loss; rom_ready SHALL stay low until the new drain completes.
REQ-031 ioctl_wr with ioctl_downl low SHALL be ignored.

Reset
REQ-032 While init_n is low on a clock edge, the module SHALL reset as follows.
- FSM = IDLE, FIFO emptied, pack register cleared.
- rom_ready = 0, ioctl_wait = 0, port_we = 0, port_ds = 00, port_a = 0, port_d = 0.
- port_req takes the sampled value of port_ack, so no request is issued.
REQ-033 A reset during WAIT_ACK SHALL abandon the transfer, and the loader SHALL NOT re-issue it.

Structure
REQ-034 The FSM state encoding and the ds constants (DS_LO=01, DS_HI=10, DS_W=11) SHALL live in a shared package, sdram_loader_pkg.
REQ-035 The FIFO SHALL be one sub-module, loader_fifo, a parameterised synchronous FIFO with push, pop, full, count and head outputs.

Verification
REQ-036 Sequential bytes 0x11@0, 0x22@1 with ack echoed 3 cycles after each toggle -> one write: a=0, d=0x2211, ds=11; rom_ready rises after ioctl_downl falls.
REQ-037 Lone byte 0xAB@5, then ioctl_downl falls -> one write: a=2, d[15:8]=0xAB, ds=10.
REQ-038 Lone byte 0xCD@8, then 0xEF@12 -> write a=4, ds=01, d[7:0]=0xCD; the second byte is held until the flush, then written a=6, ds=01.
REQ-039 Burst of 16 bytes, one per cycle, ack held off for 50 cycles -> ioctl_wait rises at count 2 (FIFO_DEPTH=4), no entry is lost, and 8 writes occur in address order.
REQ-040 init_n pulsed low during WAIT_ACK with port_ack=1 -> port_req=1 after reset, no further toggle, FIFO empty, rom_ready=0.
REQ-041 BASE=0x100000, byte pair at 0x000010 -> port_a=0x100008, ds=11.
